// File: rtl/ahb_pkg.sv
// ahb_pkg: AHB-Lite encodings shared by ahb_master and ahb_slave, plus the ahb_master state encoding
package ahb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      BUSY   = 2'b01,
      NONSEQ = 2'b10,
      SEQ    = 2'b11
   } htrans_t;

   localparam logic [2:0] HSIZE_BYTE    = 3'b000;
   localparam logic [2:0] HSIZE_HALF    = 3'b001;
   localparam logic [2:0] HSIZE_WORD    = 3'b010;
   localparam logic [2:0] HBURST_SINGLE = 3'b000;
   localparam logic       HRESP_OKAY    = 1'b0;
   localparam logic       HRESP_ERROR   = 1'b1;

   // ahb_master state is the pair {a_vld, d_vld}
   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE = 2'b00;
   localparam state_t ST_ADDR = 2'b10;
   localparam state_t ST_PIPE = 2'b11;
   localparam state_t ST_DATA = 2'b01;

endpackage

// File: rtl/ahb_master.sv
// ahb_master: valid/ready requests to AHB-Lite SINGLE transfers, address phase overlapping data phase
module ahb_master
   import ahb_pkg::*;
#(
   parameter int         DATA_WIDTH = 32,
   parameter int         ADDR_WIDTH = 32,
   parameter logic [2:0] HSIZE      = HSIZE_WORD
) (
   input  logic                  i_clk_ahb,
   input  logic                  i_rstn_ahb,
   input  logic                  i_valid,
   input  logic                  i_rd0_wr1,
   input  logic [ADDR_WIDTH-1:0] i_addr,
   input  logic [DATA_WIDTH-1:0] i_wr_data,
   output logic                  o_ready,
   output logic                  o_rd_valid,
   output logic [DATA_WIDTH-1:0] o_rd_data,
   output logic                  o_err,
   output logic [1:0]            o_htrans,
   output logic                  o_hwrite,
   output logic [2:0]            o_hsize,
   output logic [2:0]            o_hburst,
   output logic [ADDR_WIDTH-1:0] o_haddr,
   output logic [DATA_WIDTH-1:0] o_hwdata,
   input  logic                  i_hready,
   input  logic                  i_hresp,
   input  logic [DATA_WIDTH-1:0] i_hrdata
);

   state_t                state, state_nx;
   logic                  a_vld, d_vld, a_write, d_write, accept, complete;
   logic [ADDR_WIDTH-1:0] a_addr;
   logic [DATA_WIDTH-1:0] a_wdata;

   assign a_vld    = state[1];
   assign d_vld    = state[0];
   // A can take a request whenever it is empty or is moving into D on this edge
   assign o_ready  = !a_vld || i_hready;
   assign accept   = i_valid && o_ready;
   assign complete = d_vld && i_hready;

   // address-phase outputs come straight from the A slot; addr/write keep their last value when A empties
   assign o_htrans = a_vld ? NONSEQ : IDLE;
   assign o_haddr  = a_addr;
   assign o_hwrite = a_write;
   assign o_hsize  = HSIZE;
   assign o_hburst = HBURST_SINGLE;

   // slot occupancy: A refills whenever it can accept, D takes A on every phase advance
   always_comb begin
      state_nx = {o_ready ? i_valid : a_vld, i_hready ? a_vld : d_vld};
   end

   // slot registers; payload fields only change on accept/advance so the bus does not toggle while idle
   always_ff @(posedge i_clk_ahb or negedge i_rstn_ahb) begin
      if (!i_rstn_ahb) begin
         state   <= ST_IDLE;
         a_write <= 1'b0;
         a_addr  <= '0;
         a_wdata <= '0;
         d_write <= 1'b0;
      end else begin
         state <= state_nx;
         if (accept) begin
            a_write <= i_rd0_wr1;
            a_addr  <= i_addr;
            a_wdata <= i_wr_data;
         end
         if (i_hready) d_write <= a_write;
      end
   end

   // write data register, loaded as a write enters its data phase and held through wait states
   always_ff @(posedge i_clk_ahb or negedge i_rstn_ahb) begin
      if (!i_rstn_ahb) o_hwdata <= '0;
      else if (i_hready && a_vld && a_write) o_hwdata <= a_wdata;
   end

   // completion reporting: one-cycle read/error pulses, read data held until the next read completes
   always_ff @(posedge i_clk_ahb or negedge i_rstn_ahb) begin
      if (!i_rstn_ahb) begin
         o_rd_valid <= 1'b0;
         o_err      <= 1'b0;
         o_rd_data  <= '0;
      end else begin
         o_rd_valid <= complete && !d_write;
         o_err      <= complete && (i_hresp == HRESP_ERROR);
         if (complete && !d_write) o_rd_data <= i_hrdata;
      end
   end

endmodule

// File: tb/tb_ahb_master.sv
// tb_ahb_master: directed stimulus with a transaction-queue model checked every cycle plus literal spot checks
module tb_ahb_master;

   localparam int DW = 32;
   localparam int AW = 32;

   logic          clk = 1'b0, rstn = 1'b0;
   logic          i_valid = 1'b0, i_rd0_wr1 = 1'b0, i_hready = 1'b1, i_hresp = 1'b0;
   logic [AW-1:0] i_addr = '0;
   logic [DW-1:0] i_wr_data = '0, i_hrdata = '0;
   logic          o_ready, o_rd_valid, o_err, o_hwrite;
   logic [DW-1:0] o_rd_data, o_hwdata;
   logic [1:0]    o_htrans;
   logic [2:0]    o_hsize, o_hburst;
   logic [AW-1:0] o_haddr;

   always #5 clk = ~clk;

   ahb_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .HSIZE(3'b010)) dut (
      .i_clk_ahb(clk), .i_rstn_ahb(rstn), .i_valid(i_valid), .i_rd0_wr1(i_rd0_wr1),
      .i_addr(i_addr), .i_wr_data(i_wr_data), .o_ready(o_ready), .o_rd_valid(o_rd_valid),
      .o_rd_data(o_rd_data), .o_err(o_err), .o_htrans(o_htrans), .o_hwrite(o_hwrite),
      .o_hsize(o_hsize), .o_hburst(o_hburst), .o_haddr(o_haddr), .o_hwdata(o_hwdata),
      .i_hready(i_hready), .i_hresp(i_hresp), .i_hrdata(i_hrdata)
   );

   typedef struct {
      logic          w;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } req_t;

   req_t          aq[$], dq[$];
   int            n_cmp = 0, n_bad = 0, n_rv = 0, n_err = 0;
   logic [AW-1:0] m_addr = '0;
   logic          m_write = 1'b0, m_rv = 1'b0, m_err = 1'b0, rdy;
   logic [DW-1:0] m_hwdata = '0, m_rdata = '0;

   task automatic cmp(input string nm, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
      end
   endtask

   // model: requests queue for their address phase, then their data phase; the bus address always
   // shows the most recently accepted request; completions surface as next-cycle pulses
   always @(negedge clk) begin
      if (!rstn) begin
         aq.delete();
         dq.delete();
         m_addr = '0; m_write = 1'b0; m_hwdata = '0; m_rdata = '0; m_rv = 1'b0; m_err = 1'b0;
      end
      rdy = (aq.size() == 0) || i_hready;
      cmp("ready", 64'(o_ready), 64'(rdy));
      cmp("htrans", 64'(o_htrans), aq.size() != 0 ? 64'h2 : 64'h0);
      cmp("haddr", 64'(o_haddr), 64'(m_addr));
      cmp("hwrite", 64'(o_hwrite), 64'(m_write));
      cmp("hwdata", 64'(o_hwdata), 64'(m_hwdata));
      cmp("rd_valid", 64'(o_rd_valid), 64'(m_rv));
      cmp("err", 64'(o_err), 64'(m_err));
      cmp("rd_data", 64'(o_rd_data), 64'(m_rdata));
      cmp("hsize", 64'(o_hsize), 64'h2);
      cmp("hburst", 64'(o_hburst), 64'h0);
      if (o_rd_valid) n_rv++;
      if (o_err) n_err++;
      if (rstn) begin
         m_rv = 1'b0;
         m_err = 1'b0;
         if (dq.size() != 0 && i_hready) begin
            m_rv = !dq[0].w;
            m_err = i_hresp;
            if (!dq[0].w) m_rdata = i_hrdata;
            void'(dq.pop_front());
         end
         if (i_hready && aq.size() != 0) begin
            if (aq[0].w) m_hwdata = aq[0].d;
            dq.push_back(aq.pop_front());
         end
         if (i_valid && rdy) begin
            aq.push_back('{w: i_rd0_wr1, a: i_addr, d: i_wr_data});
            m_addr = i_addr;
            m_write = i_rd0_wr1;
         end
      end
   end

   task automatic cyc(input logic v, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic hr, input logic rsp, input logic [DW-1:0] rd);
      @(posedge clk);
      #1;
      i_valid = v; i_rd0_wr1 = w; i_addr = a; i_wr_data = d;
      i_hready = hr; i_hresp = rsp; i_hrdata = rd;
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) cyc(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, '0);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #3 rstn = 1'b1;
      #1;
      cmp("rst_ready", 64'(o_ready), 64'h1);
      cmp("rst_htrans", 64'(o_htrans), 64'h0);
      cmp("rst_haddr", 64'(o_haddr), 64'h0);

      // single zero-wait read
      cyc(1, 0, 32'h10, 0, 1, 0, 0);
      cmp("t1_ready", 64'(o_ready), 64'h1);
      idle(1);
      cmp("t1_htrans", 64'(o_htrans), 64'h2);
      cmp("t1_haddr", 64'(o_haddr), 64'h10);
      cyc(0, 0, 0, 0, 1, 0, 32'hDEAD_BEEF);
      cmp("t1_htrans_idle", 64'(o_htrans), 64'h0);
      cmp("t1_rv_early", 64'(o_rd_valid), 64'h0);
      idle(1);
      cmp("t1_rv", 64'(o_rd_valid), 64'h1);
      cmp("t1_rdata", 64'(o_rd_data), 64'hDEAD_BEEF);
      idle(1);
      cmp("t1_rv_once", 64'(o_rd_valid), 64'h0);
      cmp("t1_rdata_hold", 64'(o_rd_data), 64'hDEAD_BEEF);

      // back-to-back writes
      cyc(1, 1, 32'h100, 1, 1, 0, 0);
      cyc(1, 1, 32'h104, 2, 1, 0, 0);
      cmp("t2_haddr0", 64'(o_haddr), 64'h100);
      cmp("t2_ready0", 64'(o_ready), 64'h1);
      cyc(1, 1, 32'h108, 3, 1, 0, 0);
      cmp("t2_haddr1", 64'(o_haddr), 64'h104);
      cmp("t2_hwdata0", 64'(o_hwdata), 64'h1);
      idle(1);
      cmp("t2_haddr2", 64'(o_haddr), 64'h108);
      cmp("t2_htrans2", 64'(o_htrans), 64'h2);
      cmp("t2_hwdata1", 64'(o_hwdata), 64'h2);
      idle(1);
      cmp("t2_hwdata2", 64'(o_hwdata), 64'h3);
      cmp("t2_htrans_idle", 64'(o_htrans), 64'h0);

      // read with two wait states, write pending in A, third request held by requester
      cyc(1, 0, 32'h20, 0, 1, 0, 0);
      cyc(1, 1, 32'h24, 32'hAA, 1, 0, 0);
      cmp("t3_haddr_rd", 64'(o_haddr), 64'h20);
      cyc(1, 0, 32'h28, 0, 0, 0, 0);
      cmp("t3_haddr_w1", 64'(o_haddr), 64'h24);
      cmp("t3_ready_w1", 64'(o_ready), 64'h0);
      cyc(1, 0, 32'h28, 0, 0, 0, 0);
      cmp("t3_haddr_w2", 64'(o_haddr), 64'h24);
      cmp("t3_ready_w2", 64'(o_ready), 64'h0);
      cyc(1, 0, 32'h28, 0, 1, 0, 32'h1234_5678);
      cmp("t3_ready_go", 64'(o_ready), 64'h1);
      cyc(0, 0, 0, 0, 1, 0, 0);
      cmp("t3_rv", 64'(o_rd_valid), 64'h1);
      cmp("t3_rdata", 64'(o_rd_data), 64'h1234_5678);
      cmp("t3_hwdata", 64'(o_hwdata), 64'hAA);
      cmp("t3_haddr3", 64'(o_haddr), 64'h28);
      cyc(0, 0, 0, 0, 1, 0, 32'h2828_2828);
      cmp("t3_no_wr_pulse", 64'(o_rd_valid), 64'h0);
      idle(1);
      cmp("t3_rdata2", 64'(o_rd_data), 64'h2828_2828);

      // write answered with a two-cycle ERROR, followed by an OKAY read
      cyc(1, 1, 32'h30, 32'h55, 1, 0, 0);
      cyc(1, 0, 32'h34, 0, 1, 0, 0);
      cmp("t4_haddr", 64'(o_haddr), 64'h30);
      cmp("t4_hwrite", 64'(o_hwrite), 64'h1);
      cyc(0, 0, 0, 0, 0, 1, 0);
      cmp("t4_hwdata", 64'(o_hwdata), 64'h55);
      cmp("t4_haddr_rd", 64'(o_haddr), 64'h34);
      cyc(0, 0, 0, 0, 1, 1, 0);
      cmp("t4_err_early", 64'(o_err), 64'h0);
      cyc(0, 0, 0, 0, 1, 0, 32'h3434);
      cmp("t4_err", 64'(o_err), 64'h1);
      idle(1);
      cmp("t4_err_once", 64'(o_err), 64'h0);
      cmp("t4_rv", 64'(o_rd_valid), 64'h1);
      cmp("t4_rdata", 64'(o_rd_data), 64'h3434);

      // idle requester: bus parked and stable
      idle(10);
      cmp("t6_htrans", 64'(o_htrans), 64'h0);
      cmp("t6_haddr", 64'(o_haddr), 64'h34);
      cmp("t6_hwrite", 64'(o_hwrite), 64'h0);
      cmp("t6_hwdata", 64'(o_hwdata), 64'h55);

      // reset in the middle of a wait-stated read
      cyc(1, 0, 32'h40, 0, 1, 0, 0);
      idle(1);
      cyc(0, 0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0);
      #1 rstn = 1'b0;
      #1;
      cmp("t5_htrans", 64'(o_htrans), 64'h0);
      cmp("t5_haddr", 64'(o_haddr), 64'h0);
      cmp("t5_hwdata", 64'(o_hwdata), 64'h0);
      cmp("t5_rdata", 64'(o_rd_data), 64'h0);
      cmp("t5_ready", 64'(o_ready), 64'h1);
      idle(1);
      #1 rstn = 1'b1;
      idle(1);
      cmp("t5_no_rv", 64'(o_rd_valid), 64'h0);
      cyc(1, 0, 32'h44, 0, 1, 0, 0);
      idle(1);
      cmp("t5_htrans_new", 64'(o_htrans), 64'h2);
      cmp("t5_haddr_new", 64'(o_haddr), 64'h44);
      cyc(0, 0, 0, 0, 1, 0, 32'h4444);
      idle(1);
      cmp("t5_rv", 64'(o_rd_valid), 64'h1);
      cmp("t5_rdata_new", 64'(o_rd_data), 64'h4444);
      idle(2);

      cmp("total_rd_pulses", 64'(n_rv), 64'd5);
      cmp("total_err_pulses", 64'(n_err), 64'd1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
